// File: rtl/load_seq_ctrl_pkg.sv
// Shared constants, state encoding and small helpers for the layer-load sequencer.
package load_seq_ctrl_pkg;

  localparam int W_WORDS_DEF   = 200;
  localparam int FM_PIXELS_DEF = 12544;
  localparam int N_BATCH_DEF   = 8;
  localparam int FM_BASE_DEF   = 200;
  localparam int AW_DEF        = 20;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_WLOAD    = 3'd1,
    ST_WGAP     = 3'd2,
    ST_FMLOAD   = 3'd3,
    ST_FMHOLD   = 3'd4,
    ST_WAITDONE = 3'd5
  } state_e;

  function automatic logic is_rd_state(input state_e s);
    return (s == ST_WLOAD) || (s == ST_FMLOAD);
  endfunction

endpackage

// File: rtl/load_addr_gen.sv
// Weight/pixel/batch counters and the feature-map address adder.
// Counters always hold the address of the read presented this cycle; addr_nxt is the next one.
module load_addr_gen
  import load_seq_ctrl_pkg::*;
#(
  parameter int W_WORDS   = W_WORDS_DEF,
  parameter int FM_PIXELS = FM_PIXELS_DEF,
  parameter int N_BATCH   = N_BATCH_DEF,
  parameter int FM_BASE   = FM_BASE_DEF,
  parameter int AW        = AW_DEF
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr,
  input  logic          w_adv,
  input  logic          f_adv,
  input  logic          sel_fm,
  output logic          w_last,
  output logic          f_last,
  output logic [AW-1:0] addr_nxt
);

  localparam logic [7:0]  W_LAST     = 8'(W_WORDS - 1);
  localparam logic [13:0] PIX_LAST   = 14'(FM_PIXELS - 1);
  localparam logic [2:0]  BATCH_LAST = 3'(N_BATCH - 1);

  logic [7:0]    wcnt_q, wcnt_d;
  logic [13:0]   pix_q, pix_d;
  logic [2:0]    batch_q, batch_d;
  logic [AW-1:0] fm_addr_s;

  assign w_last = (wcnt_q == W_LAST);
  assign f_last = (pix_q == PIX_LAST) && (batch_q == BATCH_LAST);

  // Next counter values: cleared on a new layer, advanced once per issued read.
  always_comb begin
    wcnt_d  = wcnt_q;
    pix_d   = pix_q;
    batch_d = batch_q;
    if (clr) begin
      wcnt_d  = 8'd0;
      pix_d   = 14'd0;
      batch_d = 3'd0;
    end else begin
      if (w_adv) begin
        wcnt_d = wcnt_q + 8'd1;
      end else begin
        wcnt_d = wcnt_q;
      end
      if (f_adv) begin
        if (pix_q == PIX_LAST) begin
          pix_d   = 14'd0;
          batch_d = batch_q + 3'd1;
        end else begin
          pix_d   = pix_q + 14'd1;
          batch_d = batch_q;
        end
      end else begin
        pix_d   = pix_q;
        batch_d = batch_q;
      end
    end
  end

  // Address of the next read, formed from the next counter values.
  always_comb begin
    fm_addr_s = AW'(FM_BASE) + (AW'(batch_d) * AW'(FM_PIXELS)) + AW'(pix_d);
    if (sel_fm) begin
      addr_nxt = fm_addr_s;
    end else begin
      addr_nxt = AW'(wcnt_d);
    end
  end

  // Counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wcnt_q  <= 8'd0;
      pix_q   <= 14'd0;
      batch_q <= 3'd0;
    end else begin
      wcnt_q  <= wcnt_d;
      pix_q   <= pix_d;
      batch_q <= batch_d;
    end
  end

endmodule

// File: rtl/load_seq_ctrl.sv
// Layer-load sequencer: streams weights then feature-map planes from memory to the accelerator.
// All outputs are registered; the stream lags the read strobe by two cycles.
module load_seq_ctrl
  import load_seq_ctrl_pkg::*;
#(
  parameter int W_WORDS   = W_WORDS_DEF,
  parameter int FM_PIXELS = FM_PIXELS_DEF,
  parameter int N_BATCH   = N_BATCH_DEF,
  parameter int FM_BASE   = FM_BASE_DEF,
  parameter int AW        = AW_DEF
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic          abort,
  output logic          mem_rd_en,
  output logic [AW-1:0] mem_addr,
  input  logic [31:0]   mem_rdata,
  input  logic          weight_ing,
  input  logic          conv_done,
  output logic [31:0]   data_i,
  output logic          valid_i,
  output logic          busy,
  output logic          done
);

  state_e        state_q, state_d;
  logic          mem_rd_en_q, mem_rd_en_d;
  logic [AW-1:0] mem_addr_q, mem_addr_d;
  logic          rd_d1_q, rd_d1_d;
  logic          valid_i_q, valid_i_d;
  logic [31:0]   data_i_q, data_i_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          clr_s, w_adv_s, f_adv_s, sel_fm_s, w_last_s, f_last_s;
  logic [AW-1:0] addr_nxt_s;

  load_addr_gen #(
    .W_WORDS  (W_WORDS),
    .FM_PIXELS(FM_PIXELS),
    .N_BATCH  (N_BATCH),
    .FM_BASE  (FM_BASE),
    .AW       (AW)
  ) u_addr_gen (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (clr_s),
    .w_adv   (w_adv_s),
    .f_adv   (f_adv_s),
    .sel_fm  (sel_fm_s),
    .w_last  (w_last_s),
    .f_last  (f_last_s),
    .addr_nxt(addr_nxt_s)
  );

  // State transitions; abort overrides everything, including a simultaneous start.
  always_comb begin
    state_d = state_q;
    done_d  = 1'b0;
    clr_s   = 1'b0;
    if (abort) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            state_d = ST_WLOAD;
            clr_s   = 1'b1;
          end else begin
            state_d = ST_IDLE;
          end
        end
        ST_WLOAD: begin
          if (w_last_s) state_d = ST_WGAP;
          else          state_d = ST_WLOAD;
        end
        ST_WGAP: begin
          if (!weight_ing) state_d = ST_FMLOAD;
          else             state_d = ST_WGAP;
        end
        ST_FMLOAD: begin
          if (f_last_s)        state_d = ST_WAITDONE;
          else if (weight_ing) state_d = ST_FMHOLD;
          else                 state_d = ST_FMLOAD;
        end
        ST_FMHOLD: begin
          if (!weight_ing) state_d = ST_FMLOAD;
          else             state_d = ST_FMHOLD;
        end
        ST_WAITDONE: begin
          if (conv_done) begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
          end else begin
            state_d = ST_WAITDONE;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // Read strobe/address for the next cycle and the two-stage stream pipeline.
  always_comb begin
    w_adv_s     = (state_q == ST_WLOAD);
    f_adv_s     = (state_q == ST_FMLOAD);
    sel_fm_s    = (state_d == ST_FMLOAD);
    mem_rd_en_d = is_rd_state(state_d);
    if (mem_rd_en_d) begin
      mem_addr_d = addr_nxt_s;
    end else begin
      mem_addr_d = mem_addr_q;
    end
    rd_d1_d   = mem_rd_en_q && !abort;
    valid_i_d = rd_d1_q && !abort;
    if (rd_d1_q && !abort) begin
      data_i_d = mem_rdata;
    end else begin
      data_i_d = data_i_q;
    end
    busy_d = (state_d != ST_IDLE) || done_d;
  end

  // FSM and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      mem_rd_en_q <= 1'b0;
      mem_addr_q  <= '0;
      rd_d1_q     <= 1'b0;
      valid_i_q   <= 1'b0;
      data_i_q    <= 32'd0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      mem_rd_en_q <= mem_rd_en_d;
      mem_addr_q  <= mem_addr_d;
      rd_d1_q     <= rd_d1_d;
      valid_i_q   <= valid_i_d;
      data_i_q    <= data_i_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign mem_rd_en = mem_rd_en_q;
  assign mem_addr  = mem_addr_q;
  assign data_i    = data_i_q;
  assign valid_i   = valid_i_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule

// File: tb/tb_load_seq_ctrl.sv
// Scoreboard bench for load_seq_ctrl: expected read addresses and stream words are queued
// when a layer is started; an independent monitor pops and compares on every read and valid word.
module tb_load_seq_ctrl;

  localparam int W  = 200;
  localparam int FP = 12544;
  localparam int NB = 2;
  localparam int FB = 200;
  localparam int AW = 20;
  localparam int LAYER_READS = W + NB * FP;
  localparam int LAST_ADDR   = FB + NB * FP - 1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic          mem_rd_en;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_rdata = 32'd0;
  logic          weight_ing = 1'b1;
  logic          conv_done = 1'b0;
  logic [31:0]   data_i;
  logic          valid_i;
  logic          busy;
  logic          done;

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  int done_cnt = 0;
  int addr_q[$];
  logic [31:0] data_q[$];

  load_seq_ctrl #(
    .W_WORDS(W), .FM_PIXELS(FP), .N_BATCH(NB), .FM_BASE(FB), .AW(AW)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .mem_rd_en(mem_rd_en), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
    .weight_ing(weight_ing), .conv_done(conv_done),
    .data_i(data_i), .valid_i(valid_i), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_5A5A;
  endfunction

  // Memory answers one cycle after the strobe; otherwise it returns noise.
  always @(posedge clk) begin
    if (mem_rd_en) mem_rdata <= mem_word(32'(mem_addr));
    else           mem_rdata <= $urandom;
  end

  // i-th read of a layer: all weights, then each batch plane pixel by pixel.
  function automatic int layer_addr(input int i);
    int j;
    if (i < W) return i;
    j = i - W;
    return FB + (j / FP) * FP + (j % FP);
  endfunction

  task automatic push_layer(input int n_reads, input int n_stream);
    for (int i = 0; i < n_reads; i++) addr_q.push_back(layer_addr(i));
    for (int i = 0; i < n_stream; i++) data_q.push_back(mem_word(32'(layer_addr(i))));
  endtask

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic wait_addr(input int a, input int budget, input string nm, output int at);
    bit found;
    found = 1'b0;
    at = -1;
    for (int i = 0; i < budget && !found; i++) begin
      @(negedge clk);
      if (mem_rd_en && (int'(mem_addr) == a)) begin
        found = 1'b1;
        at = cyc;
      end
    end
    check(nm, 64'(found), 64'd1);
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_rd_en"}, 64'(mem_rd_en), 64'd0);
    check({tag, "_addr"},  64'(mem_addr), 64'd0);
    check({tag, "_valid"}, 64'(valid_i), 64'd0);
    check({tag, "_data"},  64'(data_i), 64'd0);
    check({tag, "_busy"},  64'(busy), 64'd0);
    check({tag, "_done"},  64'(done), 64'd0);
  endtask

  // Monitor: every read and every stream word is matched against the queues.
  initial begin
    bit hist1, hist2;
    int exp_a;
    hist1 = 1'b0;
    hist2 = 1'b0;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (mem_rd_en) begin
          check("read_expected", 64'(addr_q.size() != 0), 64'd1);
          if (addr_q.size() != 0) begin
            exp_a = addr_q.pop_front();
            check("rd_addr", 64'(mem_addr), 64'(exp_a));
          end
        end
        if (valid_i) begin
          check("valid_after_read", 64'(hist2), 64'd1);
          check("stream_expected", 64'(data_q.size() != 0), 64'd1);
          if (data_q.size() != 0) check("data_i", 64'(data_i), 64'(data_q.pop_front()));
        end
        if (done) done_cnt++;
        hist2 = hist1;
        hist1 = mem_rd_en;
      end else begin
        hist1 = 1'b0;
        hist2 = 1'b0;
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int t0, t1, t_start, t_drop, p, len;
    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check_outputs_zero("reset");
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check("idle_busy", 64'(busy), 64'd0);

    // Layer 1: full load with weight_ing high through the weight phase.
    push_layer(LAYER_READS, LAYER_READS);
    weight_ing = 1'b1;
    start = 1'b1;
    t_start = cyc;
    @(negedge clk);
    start = 1'b0;
    check("busy_after_start", 64'(busy), 64'd1);
    check("first_read_now", 64'(mem_rd_en && mem_addr == '0), 64'd1);
    check("first_read_cycle", 64'(cyc), 64'(t_start + 1));
    t0 = cyc;
    conv_done = 1'b1;
    start = 1'b1;
    @(negedge clk);
    conv_done = 1'b0;
    start = 1'b0;
    wait_addr(W - 1, 400, "wait_last_weight", t1);
    check("weights_consecutive", 64'(t1 - t0), 64'(W - 1));
    repeat (15) @(negedge clk);
    check("gap_no_read", 64'(mem_rd_en), 64'd0);
    weight_ing = 1'b0;
    t_drop = cyc;
    wait_addr(FB, 10, "wait_first_fm", t1);
    check("fm_start_cycle", 64'(t1), 64'(t_drop + 1));

    // Hold for 5 cycles so that pixel 100 is the resumed read.
    wait_addr(FB + 99, 200, "wait_pix99", t0);
    weight_ing = 1'b1;
    repeat (5) @(negedge clk);
    check("hold_no_read", 64'(mem_rd_en), 64'd0);
    weight_ing = 1'b0;
    wait_addr(FB + 100, 20, "wait_pix100", t1);
    check("hold5_gap", 64'(t1 - t0), 64'd6);

    // Random holds of random length at random pixels in batch 0.
    for (int k = 0; k < 3; k++) begin
      p = 1000 + k * 3000 + int'($urandom_range(0, 999));
      len = int'($urandom_range(1, 8));
      wait_addr(FB + p - 1, 5000, "wait_rand_hold", t0);
      weight_ing = 1'b1;
      repeat (len) @(negedge clk);
      weight_ing = 1'b0;
      wait_addr(FB + p, 20, "wait_rand_resume", t1);
      check("rand_hold_gap", 64'(t1 - t0), 64'(len + 1));
    end

    wait_addr(FB + FP - 1, 20000, "wait_batch0_end", t0);
    @(negedge clk);
    check("batch1_first_addr", 64'(mem_rd_en && int'(mem_addr) == FB + FP), 64'd1);

    wait_addr(LAST_ADDR, 20000, "wait_last_fm", t0);
    repeat (50) @(negedge clk);
    check("waitdone_no_read", 64'(mem_rd_en), 64'd0);
    check("waitdone_busy", 64'(busy), 64'd1);
    check("no_early_done", 64'(done_cnt), 64'd0);
    conv_done = 1'b1;
    @(negedge clk);
    conv_done = 1'b0;
    check("done_pulse", 64'(done), 64'd1);
    check("busy_on_done", 64'(busy), 64'd1);
    @(negedge clk);
    check("done_cleared", 64'(done), 64'd0);
    check("busy_dropped", 64'(busy), 64'd0);
    repeat (3) @(negedge clk);
    check("done_count_l1", 64'(done_cnt), 64'd1);
    check("l1_addr_drained", 64'(addr_q.size()), 64'd0);
    check("l1_data_drained", 64'(data_q.size()), 64'd0);

    // Layer 2: abort at pixel 3000; the two words still in flight are dropped.
    push_layer(W + 3001, W + 2999);
    weight_ing = 1'b0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_addr(FB + 3000, 5000, "wait_pix3000", t0);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("abort_rd_en", 64'(mem_rd_en), 64'd0);
    check("abort_valid", 64'(valid_i), 64'd0);
    check("abort_busy", 64'(busy), 64'd0);
    conv_done = 1'b1;
    @(negedge clk);
    conv_done = 1'b0;
    repeat (5) @(negedge clk);
    check("abort_no_done", 64'(done_cnt), 64'd1);
    check("l2_addr_drained", 64'(addr_q.size()), 64'd0);
    check("l2_data_drained", 64'(data_q.size()), 64'd0);

    // Abort together with start: start must be dropped.
    start = 1'b1;
    abort = 1'b1;
    @(negedge clk);
    start = 1'b0;
    abort = 1'b0;
    check("abort_wins_rd", 64'(mem_rd_en), 64'd0);
    check("abort_wins_busy", 64'(busy), 64'd0);
    repeat (3) @(negedge clk);

    // Layer 3: restart from address 0, then asynchronous reset mid-weight-load.
    push_layer(51, 49);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("restart_addr0", 64'(mem_rd_en && mem_addr == '0), 64'd1);
    wait_addr(50, 100, "wait_w50", t0);
    #2 rst_n = 1'b0;
    #1 check_outputs_zero("async_reset");
    @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    check("post_reset_idle_rd", 64'(mem_rd_en), 64'd0);
    check("post_reset_idle_busy", 64'(busy), 64'd0);
    check("l3_addr_drained", 64'(addr_q.size()), 64'd0);
    check("l3_data_drained", 64'(data_q.size()), 64'd0);
    check("final_done_count", 64'(done_cnt), 64'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
